fetch_prefetch_queue: RTL and testbench

//  Instruction prefetch stage that sits between IMEM and the IF_ID pipeline register.
//  It owns the fetch PC, reads IMEM combinationally and buffers {pc, inst} pairs in a

---
 rtl/fetch_prefetch_queue.sv | 58 +++++
 tb/tb_fetch_prefetch_queue.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/fetch_prefetch_queue.sv
// fetch_prefetch_queue: owns the fetch PC, reads IMEM and buffers {pc, inst} pairs
// in a DEPTH-entry FIFO presented to IF_ID with a valid/ready handshake.
module fetch_prefetch_queue #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     fetch_en,
   input  logic                     redirect,
   input  logic [31:0]              redirect_pc,
   output logic [31:0]              imem_addr,
   input  logic [31:0]              imem_inst,
   input  logic                     id_ready,
   output logic                     id_valid,
   output logic [31:0]              id_pc,
   output logic [31:0]              id_inst,
   output logic [$clog2(DEPTH):0]   q_count
);
   localparam int AW = $clog2(DEPTH);
   logic [31:0]   fetch_pc;
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [31:0]   pc_mem   [DEPTH];
   logic [31:0]   inst_mem [DEPTH];
   logic          push, pop;
   assign id_valid  = q_count != '0;
   assign pop       = id_valid & id_ready & ~redirect;
   assign push      = fetch_en & ~redirect & ((q_count < (AW+1)'(DEPTH)) | pop);
   assign imem_addr = fetch_pc;
   assign id_pc     = id_valid ? pc_mem[rd_ptr] : '0;
   assign id_inst   = id_valid ? inst_mem[rd_ptr] : NOP_INST;
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         fetch_pc <= RESET_PC;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         q_count  <= '0;
      end else if (redirect) begin
         fetch_pc <= redirect_pc & 32'hFFFF_FFFC;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         q_count  <= '0;
      end else begin
         if (push) begin
            wr_ptr   <= wr_ptr + 1'b1;
            fetch_pc <= fetch_pc + 32'd4;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         if (push != pop) q_count <= push ? q_count + 1'b1 : q_count - 1'b1;
      end
   // storage holds no reset; validity is tracked solely by q_count
   always_ff @(posedge clk)
      if (push) begin
         pc_mem[wr_ptr]   <= fetch_pc;
         inst_mem[wr_ptr] <= imem_inst;
      end
endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// tb_fetch_prefetch_queue: scoreboard bench for the prefetch queue with a word-indexed IMEM model.
module tb_fetch_prefetch_queue;
   localparam logic [31:0] NOP = 32'h0000_0013;
   logic        clk = 0, reset = 1, fetch_en = 0, redirect = 0, id_ready = 0;
   logic [31:0] redirect_pc = '0;
   logic [31:0] imem_addr, imem_inst, id_pc, id_inst;
   logic        id_valid;
   logic [2:0]  q_count;
   int          checks = 0, errors = 0;
   logic [63:0] sb[$];
   logic [31:0] m_pc = '0;

   fetch_prefetch_queue dut (
      .clk(clk), .reset(reset), .fetch_en(fetch_en), .redirect(redirect),
      .redirect_pc(redirect_pc), .imem_addr(imem_addr), .imem_inst(imem_inst),
      .id_ready(id_ready), .id_valid(id_valid), .id_pc(id_pc), .id_inst(id_inst),
      .q_count(q_count)
   );

   function automatic logic [31:0] inst_of(input logic [31:0] a);
      return 32'h100 + (a >> 2);
   endfunction

   assign imem_inst = inst_of(imem_addr);
   always #5 clk = ~clk;

   task automatic tick();
      bit p, q;
      p = sb.size() != 0 && id_ready && !redirect;
      q = fetch_en && !redirect && (sb.size() < 4 || p);
      @(posedge clk); #1;
      if (redirect) begin
         sb.delete();
         m_pc = {redirect_pc[31:2], 2'b00};
      end else begin
         if (p) void'(sb.pop_front());
         if (q) begin
            sb.push_back({m_pc, inst_of(m_pc)});
            m_pc += 32'd4;
         end
      end
   endtask

   task automatic pulse_reset();
      reset = 1; #2; reset = 0;
      sb.delete();
      m_pc = '0;
   endtask

   task automatic test_reset();
      #3;
      checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", id_valid); end
      checks++; if (id_pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h exp 0", id_pc); end
      checks++; if (id_inst !== NOP) begin errors++; $display("FAIL reset_inst got %h exp %h", id_inst, NOP); end
      checks++; if (q_count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", q_count); end
      checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr got %h exp 0", imem_addr); end
      @(posedge clk); #1;
      reset = 0;
   endtask

   task automatic test_stream();
      fetch_en = 1; id_ready = 1;
      for (int k = 1; k <= 8; k++) begin
         tick();
         checks++; if (id_pc !== 32'(4*(k-1)) || id_inst !== 32'(32'h100+k-1) || id_valid !== 1'b1) begin
            errors++; $display("FAIL stream_head k=%0d got %b %h %h exp 1 %h %h", k, id_valid, id_pc, id_inst, 4*(k-1), 32'h100+k-1);
         end
         checks++; if (q_count !== 3'd1) begin errors++; $display("FAIL stream_count k=%0d got %0d exp 1", k, q_count); end
      end
   endtask

   task automatic test_backpressure();
      logic [64:0] exp;
      pulse_reset();
      fetch_en = 1; id_ready = 0;
      for (int k = 1; k <= 6; k++) begin
         tick();
         checks++; if (q_count !== 3'(k > 4 ? 4 : k)) begin errors++; $display("FAIL bp_count k=%0d got %0d exp %0d", k, q_count, k > 4 ? 4 : k); end
      end
      checks++; if (imem_addr !== 32'h10) begin errors++; $display("FAIL bp_addr got %h exp 10", imem_addr); end
      id_ready = 1;
      tick();
      checks++; if (q_count !== 3'd4) begin errors++; $display("FAIL full_pushpop_count got %0d exp 4", q_count); end
      checks++; if (imem_addr !== 32'h14) begin errors++; $display("FAIL full_pushpop_addr got %h exp 14", imem_addr); end
      fetch_en = 0;
      for (int k = 0; k < 5; k++) begin
         if (sb.size() != 0) exp = {1'b1, sb[0]}; else exp = {1'b0, 32'h0, NOP};
         checks++; if ({id_valid, id_pc, id_inst} !== exp) begin errors++; $display("FAIL drain_head k=%0d got %h exp %h", k, {id_valid, id_pc, id_inst}, exp); end
         tick();
         checks++; if (q_count !== 3'(sb.size())) begin errors++; $display("FAIL drain_count k=%0d got %0d exp %0d", k, q_count, sb.size()); end
      end
      checks++; if (q_count !== 3'd0 || id_valid !== 1'b0) begin errors++; $display("FAIL empty_no_underflow got %0d %b exp 0 0", q_count, id_valid); end
   endtask

   task automatic test_redirect();
      fetch_en = 1; id_ready = 0;
      repeat (3) tick();
      checks++; if (q_count !== 3'd3) begin errors++; $display("FAIL redir_pre_count got %0d exp 3", q_count); end
      redirect = 1; redirect_pc = 32'h203;
      tick();
      redirect = 0; id_ready = 1;
      checks++; if (q_count !== 3'd0 || id_valid !== 1'b0) begin errors++; $display("FAIL redir_flush got %0d %b exp 0 0", q_count, id_valid); end
      checks++; if (imem_addr !== 32'h200) begin errors++; $display("FAIL redir_addr got %h exp 200", imem_addr); end
      tick();
      checks++; if (id_valid !== 1'b1 || id_pc !== 32'h200 || id_inst !== 32'h180) begin
         errors++; $display("FAIL redir_target got %b %h %h exp 1 200 180", id_valid, id_pc, id_inst);
      end
   endtask

   task automatic test_redirect_frozen();
      logic [64:0] exp;
      redirect = 1; redirect_pc = 32'h400; fetch_en = 0; id_ready = 1;
      tick();
      redirect = 0;
      checks++; if (q_count !== 3'd0 || imem_addr !== 32'h400) begin errors++; $display("FAIL frozen_flush got %0d %h exp 0 400", q_count, imem_addr); end
      tick();
      checks++; if (q_count !== 3'd0 || imem_addr !== 32'h400) begin errors++; $display("FAIL frozen_hold got %0d %h exp 0 400", q_count, imem_addr); end
      fetch_en = 1; id_ready = 0;
      repeat (3) tick();
      fetch_en = 0; id_ready = 1;
      for (int k = 0; k < 4; k++) begin
         if (sb.size() != 0) exp = {1'b1, sb[0]}; else exp = {1'b0, 32'h0, NOP};
         checks++; if ({id_valid, id_pc, id_inst} !== exp) begin errors++; $display("FAIL frozen_head k=%0d got %h exp %h", k, {id_valid, id_pc, id_inst}, exp); end
         checks++; if (imem_addr !== m_pc) begin errors++; $display("FAIL frozen_addr k=%0d got %h exp %h", k, imem_addr, m_pc); end
         tick();
      end
   endtask

   task automatic test_wrap_and_reset();
      logic [64:0] exp;
      redirect = 1; redirect_pc = 32'hFFFF_FFFC; fetch_en = 1; id_ready = 1;
      tick();
      redirect = 0;
      checks++; if (imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_start got %h exp fffffffc", imem_addr); end
      tick();
      checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_addr got %h exp 0", imem_addr); end
      checks++; if (id_pc !== 32'hFFFF_FFFC || id_inst !== 32'h4000_00FF) begin errors++; $display("FAIL wrap_head got %h %h exp fffffffc 400000ff", id_pc, id_inst); end
      tick();
      reset = 1; #1;
      checks++; if (id_valid !== 1'b0 || q_count !== 3'd0) begin errors++; $display("FAIL async_reset_q got %b %0d exp 0 0", id_valid, q_count); end
      checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL async_reset_addr got %h exp 0", imem_addr); end
      #1 reset = 0;
      sb.delete(); m_pc = '0;
      for (int k = 0; k < 4; k++) begin
         tick();
         if (sb.size() != 0) exp = {1'b1, sb[0]}; else exp = {1'b0, 32'h0, NOP};
         checks++; if ({id_valid, id_pc, id_inst} !== exp) begin errors++; $display("FAIL restart_head k=%0d got %h exp %h", k, {id_valid, id_pc, id_inst}, exp); end
         checks++; if (imem_addr !== m_pc) begin errors++; $display("FAIL restart_addr k=%0d got %h exp %h", k, imem_addr, m_pc); end
      end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect();
      test_redirect_frozen();
      test_wrap_and_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
